// File: rtl/mac_host_driver.sv
// Host-side sequencer for a byte-serial MAC block: loads operand pairs, clears and reads back
// the 24-bit accumulator. Optional shadow accumulator check enabled by MAC_HOST_SHADOW_EN.
module mac_host_driver (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [23:0] rsp_data,
   output logic        rsp_mismatch,
   output logic [7:0]  mac_ui,
   output logic        mac_load_en,
   output logic [1:0]  mac_read_sel,
   output logic        mac_clr_acc,
   input  logic [7:0]  mac_uo
);

   typedef enum logic [3:0] {
      StIdle, StLdA, StLdB, StLdZa, StLdZb, StClr, StRd0, StRd1, StRd2, StRsp
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic [23:0] rsp_data_q, rsp_data_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         rsp_data_q <= 24'h000000;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      rsp_data_d = rsp_data_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               a_d = cmd_a;
               b_d = cmd_b;
               unique case (cmd_op)
                  2'b00:   state_d = StLdA;
                  2'b01:   state_d = StClr;
                  2'b10:   state_d = StRd0;
                  default: state_d = StIdle;
               endcase
            end
         end
         StLdA:  state_d = StLdB;
         StLdB:  state_d = StLdZa;
         StLdZa: state_d = StLdZb;
         StLdZb: state_d = StIdle;
         StClr:  state_d = StIdle;
         StRd0: begin
            rsp_data_d[7:0] = mac_uo;
            state_d         = StRd1;
         end
         StRd1: begin
            rsp_data_d[15:8] = mac_uo;
            state_d          = StRd2;
         end
         StRd2: begin
            rsp_data_d[23:16] = mac_uo;
            state_d           = StRsp;
         end
         StRsp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // MAC-side strobes decode registered state only; cmd_* never reach them directly.
   always_comb begin
      mac_load_en  = 1'b0;
      mac_ui       = 8'h00;
      mac_clr_acc  = 1'b0;
      mac_read_sel = 2'b11;
      unique case (state_q)
         StLdA: begin
            mac_load_en = 1'b1;
            mac_ui      = a_q;
         end
         StLdB: begin
            mac_load_en = 1'b1;
            mac_ui      = b_q;
         end
         StLdZa, StLdZb: mac_load_en = 1'b1;
         StClr:          mac_clr_acc = 1'b1;
         StRd0:          mac_read_sel = 2'b00;
         StRd1:          mac_read_sel = 2'b01;
         StRd2:          mac_read_sel = 2'b10;
         default: ;
      endcase
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StRsp);
   assign rsp_data  = rsp_data_q;

`ifdef MAC_HOST_SHADOW_EN
   logic [23:0]        shadow_q, shadow_d;
   logic signed [15:0] prod;

   assign prod = $signed(a_q) * $signed(b_q);

   always_ff @(posedge clk) begin
      if (!rst_n) shadow_q <= 24'h000000;
      else        shadow_q <= shadow_d;
   end

   always_comb begin
      shadow_d = shadow_q;
      if (state_q == StLdA)      shadow_d = shadow_q + {{8{prod[15]}}, prod};
      else if (state_q == StClr) shadow_d = 24'h000000;
   end

   assign rsp_mismatch = (state_q == StRsp) && (rsp_data_q != shadow_q);
`else
   assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mac_host_driver.sv
// Scoreboard bench for mac_host_driver with a behavioural MAC block model attached.
module tb_mac_host_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [23:0] rsp_data;
   logic        rsp_mismatch;
   logic [7:0]  mac_ui;
   logic        mac_load_en;
   logic [1:0]  mac_read_sel;
   logic        mac_clr_acc;
   logic [7:0]  mac_uo;

   int n_tests = 0;
   int n_fail  = 0;

   logic [24:0] sb[$];  // {mismatch, data}

   always #5 clk = ~clk;

   mac_host_driver dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_mismatch (rsp_mismatch),
      .mac_ui       (mac_ui),
      .mac_load_en  (mac_load_en),
      .mac_read_sel (mac_read_sel),
      .mac_clr_acc  (mac_clr_acc),
      .mac_uo       (mac_uo)
   );

   // MAC model: load strobes alternate between operand registers; product accumulates each cycle.
   logic signed [7:0]  m_a, m_b;
   logic               m_par;
   logic [23:0]        m_acc;
   logic               force_ff;
   logic signed [15:0] m_prod;

   assign m_prod = m_a * m_b;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_a <= 8'sd0; m_b <= 8'sd0; m_par <= 1'b0; m_acc <= 24'h0;
      end else begin
         if (mac_clr_acc) m_acc <= 24'h0;
         else             m_acc <= m_acc + {{8{m_prod[15]}}, m_prod};
         if (mac_load_en) begin
            if (!m_par) m_a <= mac_ui;
            else        m_b <= mac_ui;
            m_par <= ~m_par;
         end
      end
   end

   always_comb begin
      case (mac_read_sel)
         2'b00:   mac_uo = m_acc[7:0];
         2'b01:   mac_uo = m_acc[15:8];
         2'b10:   mac_uo = m_acc[23:16];
         default: mac_uo = 8'h00;
      endcase
      if (force_ff) mac_uo = 8'hFF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted response is popped and compared.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            logic [24:0] e;
            e = sb.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e[23:0]));
            chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e[24]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (!cmd_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL cmd_ready_timeout: got 0, expected 1");
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
   endtask

   task automatic mac_pair(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] exp_ui [4];
      exp_ui = '{a, b, 8'h00, 8'h00};
      send(2'b00, a, b);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("load_en_seq", 32'(mac_load_en), 32'd1);
         chk("mac_ui_seq", 32'(mac_ui), 32'(exp_ui[i]));
         step();
      end
      @(negedge clk);
      chk("load_en_done", 32'(mac_load_en), 32'd0);
      step();
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rsp_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic read(input logic [23:0] exp_data, input logic exp_mis);
      sb.push_back({exp_mis, exp_data});
      send(2'b10, 8'h00, 8'h00);
      wait_rsp();
   endtask

   task automatic clear_chk();
      send(2'b01, 8'h00, 8'h00);
      @(negedge clk);
      chk("clr_pulse", 32'(mac_clr_acc), 32'd1);
      step();
      @(negedge clk);
      chk("clr_once", 32'(mac_clr_acc), 32'd0);
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      rsp_ready = 1'b1;
      force_ff  = 1'b0;
      step(); step();
      rst_n = 1'b1;

      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_mismatch", 32'(rsp_mismatch), 32'd0);
      chk("rst_outputs", {mac_ui, 5'd0, mac_load_en, mac_clr_acc, mac_read_sel},
          {8'h00, 5'd0, 1'b0, 1'b0, 2'b11});
      step();

      mac_pair(8'd3, 8'd4);
      read(24'h00000C, 1'b0);

      clear_chk();
      mac_pair(8'h80, 8'h80);
      mac_pair(8'h80, 8'h80);
      read(24'h008000, 1'b0);

      clear_chk();
      mac_pair(8'hFF, 8'h01);
      read(24'hFFFFFF, 1'b0);

      // No-op: nothing leaves IDLE.
      send(2'b11, 8'h55, 8'h66);
      @(negedge clk);
      chk("noop_ready", 32'(cmd_ready), 32'd1);
      chk("noop_quiet", {30'd0, mac_load_en, mac_clr_acc}, 32'd0);
      step();

      // Backpressured read: response must hold.
      rsp_ready = 1'b0;
      sb.push_back({1'b0, 24'hFFFFFF});
      send(2'b10, 8'h00, 8'h00);
      step(); step(); step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", 32'(rsp_data), 32'hFFFFFF);
         chk("hold_busy", 32'(cmd_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      chk("release_ready", 32'(cmd_ready), 32'd1);
      wait_rsp();

      // Reset in the middle of a load sequence.
      send(2'b00, 8'd7, 8'd7);
      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      chk("midrst_load_en", 32'(mac_load_en), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      step();
      rst_n = 1'b1;
      mac_pair(8'd2, 8'd5);
      read(24'h00000A, 1'b0);

`ifdef MAC_HOST_SHADOW_EN
      clear_chk();
      mac_pair(8'd3, 8'd4);
      sb.push_back({1'b1, 24'h00FF0C});
      send(2'b10, 8'h00, 8'h00);
      step();
      force_ff = 1'b1;
      step();
      force_ff = 1'b0;
      wait_rsp();
`endif

      step(); step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_host_driver.md
MAC_HOST_DRIVER -- requirements
Module: mac_host_driver

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low; it is shared with the attached MAC block.
REQ-003 SHALL have port cmd_valid, input, 1: command offered.
REQ-004 SHALL have port cmd_ready, output, 1: driver can accept a command.
REQ-005 SHALL have port cmd_op, input, 2: 00 MAC pair, 01 CLEAR, 10 READ, 11 no-op.
REQ-006 SHALL have ports cmd_a and cmd_b, input, 8 each: signed operands for a MAC pair.
REQ-007 SHALL have port rsp_valid, output, 1: read result available.
REQ-008 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port rsp_data, output, 24: accumulator value read back.
REQ-010 SHALL have port rsp_mismatch, output, 1: readback differs from the shadow model (see Configuration).
REQ-011 SHALL have ports mac_ui (output, 8), mac_load_en (output, 1), mac_read_sel (output, 2), mac_clr_acc (output, 1): these drive the MAC operand bus, load strobe, byte select and clear.
REQ-012 SHALL have port mac_uo, input, 8: MAC output byte, combinational from the MAC accumulator.

Function
REQ-013 SHALL implement an FSM with states IDLE, LD_A, LD_B, LD_ZA, LD_ZB, CLR, RD0, RD1, RD2, RSP.
REQ-014 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge with cmd_valid&&cmd_ready, and cmd_a/cmd_b are latched at that edge.
REQ-015 SHALL, after accepting a MAC pair, step LD_A->LD_B->LD_ZA->LD_ZB->IDLE, with mac_load_en=1 in all four states and mac_ui = A, B, 0x00, 0x00 respectively.
- This sequence loads each operand once and then zeroes both MAC operand registers.
- The MAC therefore accumulates A*B exactly once.
- The MAC load-toggle parity returns to even after every pair.
REQ-016 SHALL permit back-to-back MAC pairs, one every 5 cycles: the accept cycle plus 4 load cycles.
REQ-017 SHALL, on accepting CLEAR, spend one cycle in CLR with mac_clr_acc=1, then return to IDLE.
REQ-018 SHALL, on accepting READ, step RD0->RD1->RD2->RSP.
- mac_read_sel = 00, 01, 10 in RD0, RD1, RD2 respectively.
- mac_uo is captured at the end of each state into rsp_data[7:0], [15:8], [23:16] respectively.
REQ-019 SHALL, in RSP, hold rsp_valid=1 and rsp_data stable until rsp_ready=1, then go to IDLE at the next edge.
REQ-020 SHALL accept op 11 as a no-op: remain in IDLE with no MAC-side activity.
REQ-021 SHALL drive these defaults outside the states named above: mac_load_en=0, mac_ui=0x00, mac_clr_acc=0, mac_read_sel=11.
REQ-022 SHALL derive all mac_* outputs from registered state only, with no combinational path from the cmd_* inputs.
REQ-023 SHALL ignore cmd_valid while cmd_ready=0; such a command is neither accepted nor queued.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, enter IDLE from any state, including mid-sequence.
REQ-025 SHALL hold these reset values: cmd_ready=1 after reset, rsp_valid=0, rsp_data=0, rsp_mismatch=0, mac_load_en=0, mac_ui=0, mac_clr_acc=0, mac_read_sel=11, latched operands 0, shadow accumulator 0.

Configuration
REQ-026 SHALL, when macro MAC_HOST_SHADOW_EN is defined, keep a 24-bit shadow accumulator updated as follows:
- on each MAC pair: += sign-extend(A*B), wrapping modulo 2^24;
- on CLEAR: cleared to 0;
- in RSP: rsp_mismatch = (rsp_data != shadow), held with rsp_valid.
REQ-027 SHALL, without MAC_HOST_SHADOW_EN, contain no shadow logic, with rsp_mismatch tied 0.

Verification
REQ-028 SHALL cover: reset, MAC(3,4), READ -> mac_load_en high 4 cycles with mac_ui 03,04,00,00; rsp_data=0x00000C; rsp_mismatch=0.
REQ-029 SHALL cover: MAC(-128,-128) twice, READ -> rsp_data=0x008000.
REQ-030 SHALL cover: CLEAR, MAC(-1,1), READ -> mac_clr_acc high exactly 1 cycle; rsp_data=0xFFFFFF.
REQ-031 SHALL cover: READ with rsp_ready low 5 cycles -> rsp_valid and rsp_data held, cmd_ready=0; rsp_ready=1 -> cmd_ready=1 the following cycle.
REQ-032 SHALL cover: rst_n low during LD_B -> next cycle IDLE, mac_load_en=0; then MAC(2,5), READ -> 0x00000A.
REQ-033 SHALL cover, with MAC_HOST_SHADOW_EN defined: MAC(3,4), READ with mac_uo forced to 0xFF during RD1 -> rsp_data=0x00FF0C, rsp_mismatch=1.
